// File: rtl/drive_loader.sv
// Block copy from the storage drive into main memory: one pipelined drive read per cycle,
// with each returned word written to memory one cycle after the drive registers it.
module drive_loader #(
  parameter int DW             = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int CNT_WIDTH      = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_base,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_base,
  input  logic [CNT_WIDTH-1:0]      word_count,
  output logic [ADDR_WIDTH-1:0]     drive_address,
  input  logic [DW-1:0]             drive_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DW-1:0]             mem_data,
  output logic                      mem_write_enable,
  output logic                      busy,
  output logic                      done
);

  // state  | meaning
  // IDLE   | waiting for start
  // STREAM | issuing one drive address per cycle
  // DRAIN  | last address issued, waiting for the read pipeline to empty
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_ONE  = MEM_ADDR_WIDTH'(1);

  logic [1:0]                state;
  logic [CNT_WIDTH-1:0]      issue_left;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr;
  // issue_v: drive_address holds a live request; data_v: drive_data carries its word
  logic                      issue_v;
  logic                      data_v;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      issue_left       <= '0;
      wr_addr          <= '0;
      issue_v          <= 1'b0;
      data_v           <= 1'b0;
      drive_address    <= '0;
      mem_address      <= '0;
      mem_data         <= '0;
      mem_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done   <= 1'b0;
      data_v <= issue_v;

      if (data_v) begin
        mem_write_enable <= 1'b1;
        mem_address      <= wr_addr;
        mem_data         <= drive_data;
        wr_addr          <= wr_addr + MEM_ONE;
      end else begin
        mem_write_enable <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              drive_address <= src_base;
              wr_addr       <= dst_base;
              issue_left    <= word_count - CNT_ONE;
              issue_v       <= 1'b1;
              busy          <= 1'b1;
              state         <= STREAM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (issue_left == '0) begin
            issue_v <= 1'b0;
            state   <= DRAIN;
          end else begin
            drive_address <= drive_address + ADDR_ONE;
            issue_left    <= issue_left - CNT_ONE;
          end
        end
        DRAIN: begin
          // data_v low here means the final word was written on the previous edge
          if (!data_v) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_loader.sv
// Directed bench for drive_loader: a registered-output drive model plus a scoreboard of
// expected memory writes and done pulses, each tagged with the edge it must appear on.
module tb_drive_loader;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int MW = 14;
  localparam int CW = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [MW-1:0] dst_base = '0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] drive_address;
  logic [DW-1:0] drive_data = '0;
  logic [MW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_write_enable;
  logic          busy;
  logic          done;

  logic [DW-1:0] hd [0:(1<<AW)-1];

  typedef struct {
    logic [MW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  wr_t mon_e;
  int  mon_c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  drive_loader #(.DW(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .src_base         (src_base),
    .dst_base         (dst_base),
    .word_count       (word_count),
    .drive_address    (drive_address),
    .drive_data       (drive_data),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  // edge counter and drive model with registered read data
  always @(posedge clock) begin
    cyc = cyc + 1;
    drive_data <= hd[drive_address];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && mem_write_enable) begin
      check("write_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        mon_e = wr_q.pop_front();
        check("wr_addr", 64'(mem_address), 64'(mon_e.a));
        check("wr_data", 64'(mem_data), 64'(mon_e.d));
        check("wr_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
    if (reset && done) begin
      check("done_expected", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) begin
        mon_c = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  // Drives a one-cycle start and queues the writes/done it must produce; returns at E0+1.
  task automatic launch(input logic [AW-1:0] src, input logic [MW-1:0] dst, input logic [CW-1:0] n);
    logic [AW-1:0] sa;
    logic [MW-1:0] da;
    wr_t           e;
    int            e0;
    start      = 1'b1;
    src_base   = src;
    dst_base   = dst;
    word_count = n;
    e0 = cyc + 1;
    for (int i = 0; i < int'(n); i++) begin
      sa  = src + AW'(i);
      da  = dst + MW'(i);
      e.a = da;
      e.d = hd[sa];
      e.c = e0 + 2 + i;
      wr_q.push_back(e);
    end
    done_q.push_back((n == '0) ? e0 : e0 + int'(n) + 2);
    step();
    start      = 1'b0;
    src_base   = AW'($urandom);
    dst_base   = MW'($urandom);
    word_count = CW'($urandom_range(1, 9));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(wr_q.size() + done_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < (1 << AW); i++) hd[i] = DW'(i + 'h100);

    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wen", 64'(mem_write_enable), 64'd0);
    check("rst_drive_addr", 64'(drive_address), 64'd0);
    check("rst_mem_addr", 64'(mem_address), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // basic 3-word copy
    launch(14'd4, 14'h20, 15'd3);
    check("t1_busy_e0", 64'(busy), 64'd1);
    check("t1_daddr_e0", 64'(drive_address), 64'd4);
    step();
    check("t1_daddr_e1", 64'(drive_address), 64'd5);
    step();
    check("t1_daddr_e2", 64'(drive_address), 64'd6);
    step();
    check("t1_daddr_hold", 64'(drive_address), 64'd6);
    step();
    check("t1_busy_e4", 64'(busy), 64'd1);
    step();
    check("t1_busy_e5", 64'(busy), 64'd0);
    check("t1_done_e5", 64'(done), 64'd1);
    check("t1_wen_e5", 64'(mem_write_enable), 64'd0);
    check("t1_mem_addr_hold", 64'(mem_address), 64'h22);
    check("t1_mem_data_hold", 64'(mem_data), 64'h106);
    step();
    check("t1_done_e6", 64'(done), 64'd0);
    wait_drain("t1_drain", 10);

    // zero-length request
    launch(14'd7, 14'd9, 15'd0);
    check("t0_done", 64'(done), 64'd1);
    check("t0_busy", 64'(busy), 64'd0);
    check("t0_wen", 64'(mem_write_enable), 64'd0);
    step();
    check("t0_done_clr", 64'(done), 64'd0);
    check("t0_busy_after", 64'(busy), 64'd0);
    wait_drain("t0_drain", 5);

    // wrap on both address spaces
    launch(14'h3FFE, 14'h3FFF, 15'd3);
    check("wrap_daddr0", 64'(drive_address), 64'h3FFE);
    step();
    check("wrap_daddr1", 64'(drive_address), 64'h3FFF);
    step();
    check("wrap_daddr2", 64'(drive_address), 64'h0000);
    step();
    check("wrap_daddr_hold", 64'(drive_address), 64'h0000);
    wait_drain("wrap_drain", 10);

    // start while busy is ignored
    launch(14'd4, 14'h40, 15'd3);
    start      = 1'b1;
    src_base   = 14'h100;
    dst_base   = 14'h300;
    word_count = 15'd7;
    step();
    start = 1'b0;
    wait_drain("ignore_drain", 12);
    repeat (12) step();
    check("ignore_busy_end", 64'(busy), 64'd0);

    // reset during the second write of a 5-word copy
    launch(14'h10, 14'h50, 15'd5);
    step();
    step();
    step();
    check("rst_mid_wen", 64'(mem_write_enable), 64'd1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_wen0", 64'(mem_write_enable), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_daddr", 64'(drive_address), 64'd0);
    check("rst_mid_maddr", 64'(mem_address), 64'd0);
    check("rst_mid_mdata", 64'(mem_data), 64'd0);
    check("rst_mid_pending", 64'(wr_q.size()), 64'd3);
    wr_q.delete();
    done_q.delete();
    repeat (3) step();
    @(negedge clock);
    reset = 1'b1;
    repeat (8) step();
    check("rst_mid_quiet", 64'(busy), 64'd0);
    launch(14'h20, 14'h60, 15'd2);
    wait_drain("rst_restart_drain", 10);

    // back-to-back: second start issued while done is high
    launch(14'h8, 14'h70, 15'd2);
    k = 0;
    while (!done && k < 10) begin
      step();
      k++;
    end
    check("bb_done_seen", 64'(done), 64'd1);
    launch(14'h30, 14'h80, 15'd4);
    check("bb_busy", 64'(busy), 64'd1);
    wait_drain("bb_drain", 15);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
